// File: rtl/ipfilter_pkg.sv
// Shared types, constants and header field helpers for the IPv4 frame filter.
package ipfilter_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam int          HDR_BEATS      = 5;
    localparam int          PTR_W          = 3;

    // Pointer values: index of the final header beat and the "header full" count.
    localparam logic [PTR_W-1:0] LAST_HDR_IDX = PTR_W'(HDR_BEATS - 1);
    localparam logic [PTR_W-1:0] HDR_FULL     = PTR_W'(HDR_BEATS);

    // Byte offsets of the fields within the frame (Ethernet header + IPv4 header).
    localparam int ETYPE_OFS = 12;
    localparam int SRC_OFS   = 26;
    localparam int DST_OFS   = 30;

    // Beat that carries each field's first byte (8 bytes per beat).
    localparam int ETYPE_BEAT = ETYPE_OFS / 8;
    localparam int SRC_BEAT   = SRC_OFS / 8;
    localparam int DST_BEAT   = DST_OFS / 8;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_DECIDE,
        ST_FLUSH,
        ST_PASS,
        ST_DROP
    } state_e;

    // Network byte order: the first byte on the wire is the most significant.
    function automatic logic [15:0] get_ethertype(input logic [63:0] beat1);
        return {beat1[39:32], beat1[47:40]};
    endfunction

    function automatic logic [31:0] get_src_ip(input logic [63:0] beat3);
        return {beat3[23:16], beat3[31:24], beat3[39:32], beat3[47:40]};
    endfunction

    // The destination address straddles beats 3 and 4.
    function automatic logic [31:0] get_dst_ip(input logic [63:0] beat3, input logic [63:0] beat4);
        return {beat3[55:48], beat3[63:56], beat4[7:0], beat4[15:8]};
    endfunction

endpackage

// File: rtl/ipfilter_datapath_match.sv
// Table compare: one address/netmask comparator per entry, OR-reduced to a hit.
module ipfilter_match #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic [31:0] ip_i,
    input  logic        vld_i  [NUM_ENTRIES],
    input  logic [31:0] addr_i [NUM_ENTRIES],
    input  logic [31:0] mask_i [NUM_ENTRIES],
    output logic        hit_o
);

    logic [NUM_ENTRIES-1:0] hit_vec;

    // One comparator per entry; several hits still yield a single hit bit.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            assign hit_vec[gi] = vld_i[gi] &&
                                 ((ip_i & mask_i[gi]) == (addr_i[gi] & mask_i[gi]));
        end
    endgenerate

    assign hit_o = |hit_vec;

endmodule

// File: rtl/ipfilter_datapath.sv
// Inline IPv4 filter: buffer the header beats, decide, then flush + stream or discard.
module ipfilter_datapath
    import ipfilter_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter bit MATCH_DST   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        vld          [NUM_ENTRIES],
    input  logic [31:0] ipv4_addr    [NUM_ENTRIES],
    input  logic [31:0] ipv4_netmask [NUM_ENTRIES],
    output logic [31:0] drop_cnt
);

    state_e state_q, state_d;

    // Header buffer (data/keep/last/user per beat).
    logic [63:0] hdr_data_q [HDR_BEATS];
    logic [7:0]  hdr_keep_q [HDR_BEATS];
    logic        hdr_last_q [HDR_BEATS];
    logic        hdr_user_q [HDR_BEATS];

    logic [PTR_W-1:0] wr_ptr_q;     // beats buffered so far
    logic [PTR_W-1:0] rd_ptr_q;     // next buffered beat to load into the output stage
    logic             frame_end_q;  // the buffered part already contains tlast

    logic [63:0] out_data_q;
    logic [7:0]  out_keep_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic        out_user_q;
    logic [31:0] drop_cnt_q;

    logic        s_ready;
    logic        beat_acc;
    logic [15:0] ethertype;
    logic [31:0] match_ip;
    logic        hit;
    logic        drop_now;

    assign ethertype = get_ethertype(hdr_data_q[ETYPE_BEAT]);
    assign match_ip  = MATCH_DST ? get_dst_ip(hdr_data_q[DST_BEAT], hdr_data_q[DST_BEAT+1])
                                 : get_src_ip(hdr_data_q[SRC_BEAT]);

    ipfilter_match #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_match (
        .ip_i   (match_ip),
        .vld_i  (vld),
        .addr_i (ipv4_addr),
        .mask_i (ipv4_netmask),
        .hit_o  (hit)
    );

    // Runts (header never completed) always pass, so a full header is a precondition.
    assign drop_now = (wr_ptr_q == HDR_FULL) && (ethertype == ETHERTYPE_IPV4) && hit;

    // Ready is forced low while reset is held.
    assign s_axis_tready = s_ready & rst_n;
    assign beat_acc      = (state_q == ST_COLLECT) && s_axis_tvalid && s_axis_tready;
    assign drop_cnt      = drop_cnt_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the AXIS output mux (pass-through only in ST_PASS).
    always_comb begin
        state_d       = state_q;
        s_ready       = 1'b0;
        m_axis_tdata  = out_data_q;
        m_axis_tkeep  = out_keep_q;
        m_axis_tvalid = out_valid_q;
        m_axis_tlast  = out_last_q;
        m_axis_tuser  = out_user_q;
        case (state_q)
            ST_COLLECT: begin
                s_ready = 1'b1;
                if (s_axis_tvalid && ((wr_ptr_q == LAST_HDR_IDX) || s_axis_tlast)) begin
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (drop_now) begin
                    state_d = frame_end_q ? ST_COLLECT : ST_DROP;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (out_valid_q && m_axis_tready && (rd_ptr_q == wr_ptr_q)) begin
                    state_d = out_last_q ? ST_COLLECT : ST_PASS;
                end
            end
            ST_PASS: begin
                s_ready       = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DROP: begin
                s_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // Header storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            hdr_data_q[wr_ptr_q] <= s_axis_tdata;
            hdr_keep_q[wr_ptr_q] <= s_axis_tkeep;
            hdr_last_q[wr_ptr_q] <= s_axis_tlast;
            hdr_user_q[wr_ptr_q] <= s_axis_tuser;
        end
    end

    // Buffer pointers, registered output stage used while flushing, drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_end_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            if (beat_acc) begin
                wr_ptr_q    <= wr_ptr_q + 1'b1;
                frame_end_q <= s_axis_tlast;
            end
            if (state_q == ST_DECIDE) begin
                if (drop_now) begin
                    drop_cnt_q <= drop_cnt_q + 32'd1;
                end else begin
                    out_data_q  <= hdr_data_q[0];
                    out_keep_q  <= hdr_keep_q[0];
                    out_last_q  <= hdr_last_q[0];
                    out_user_q  <= hdr_user_q[0];
                    out_valid_q <= 1'b1;
                    rd_ptr_q    <= PTR_W'(1);
                end
            end
            if ((state_q == ST_FLUSH) && out_valid_q && m_axis_tready) begin
                if (rd_ptr_q != wr_ptr_q) begin
                    out_data_q <= hdr_data_q[rd_ptr_q];
                    out_keep_q <= hdr_keep_q[rd_ptr_q];
                    out_last_q <= hdr_last_q[rd_ptr_q];
                    out_user_q <= hdr_user_q[rd_ptr_q];
                    rd_ptr_q   <= rd_ptr_q + 1'b1;
                end else begin
                    out_data_q  <= '0;
                    out_keep_q  <= '0;
                    out_last_q  <= 1'b0;
                    out_user_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            end
            if ((state_q != ST_COLLECT) && (state_d == ST_COLLECT)) begin
                wr_ptr_q    <= '0;
                frame_end_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ipfilter_datapath.sv
// Directed bench for ipfilter_datapath: one TX (dst) and one RX (src) instance.
module tb_ipfilter_datapath;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_tuser;
    logic        sel;           // 0 = drive TX instance, 1 = drive RX instance
    logic        m_ready;
    logic        tv_tx, tv_rx;
    assign tv_tx = s_tvalid & ~sel;
    assign tv_rx = s_tvalid & sel;

    logic        rdy_tx, mv_tx, ml_tx, mu_tx;
    logic [63:0] md_tx;
    logic [7:0]  mk_tx;
    logic [31:0] dc_tx;
    logic        rdy_rx, mv_rx, ml_rx, mu_rx;
    logic [63:0] md_rx;
    logic [7:0]  mk_rx;
    logic [31:0] dc_rx;

    logic        vld_tx  [N];
    logic [31:0] addr_tx [N];
    logic [31:0] mask_tx [N];
    logic        vld_rx  [N];
    logic [31:0] addr_rx [N];
    logic [31:0] mask_rx [N];

    ipfilter_datapath #(.NUM_ENTRIES(N), .MATCH_DST(1'b1)) dut_tx (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(tv_tx),
        .s_axis_tready(rdy_tx), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(md_tx), .m_axis_tkeep(mk_tx), .m_axis_tvalid(mv_tx),
        .m_axis_tready(m_ready), .m_axis_tlast(ml_tx), .m_axis_tuser(mu_tx),
        .vld(vld_tx), .ipv4_addr(addr_tx), .ipv4_netmask(mask_tx), .drop_cnt(dc_tx)
    );

    ipfilter_datapath #(.NUM_ENTRIES(N), .MATCH_DST(1'b0)) dut_rx (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(tv_rx),
        .s_axis_tready(rdy_rx), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(md_rx), .m_axis_tkeep(mk_rx), .m_axis_tvalid(mv_rx),
        .m_axis_tready(m_ready), .m_axis_tlast(ml_rx), .m_axis_tuser(mu_rx),
        .vld(vld_rx), .ipv4_addr(addr_rx), .ipv4_netmask(mask_rx), .drop_cnt(dc_rx)
    );

    logic [73:0] got_q [$];
    logic [73:0] exp_q [$];
    int  passed   = 0;
    int  total    = 0;
    int  timeouts = 0;
    bit  rand_ready = 1'b0;
    int  stalls;

    // Output monitor: record every handshaked beat of the selected instance.
    always @(negedge clk) begin
        if (rst_n && m_ready && (sel ? mv_rx : mv_tx)) begin
            if (sel) got_q.push_back({md_rx, mk_rx, ml_rx, mu_rx});
            else     got_q.push_back({md_tx, mk_tx, ml_tx, mu_tx});
        end
    end

    // Downstream ready: constant 1 or a 50% random pattern, updated after each edge.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Offer one beat and hold it until the selected instance accepts it.
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                              input logic u, inout int st);
        int  n = 0;
        bit  done = 1'b0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (sel ? rdy_rx : rdy_tx) done = 1'b1;
            else begin
                st++;
                n++;
                if (n > 2000) begin
                    timeouts++;
                    $display("FAIL drive_timeout: beat not accepted after %0d cycles", n);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
    endtask

    // Build a frame (pattern bytes + ethertype/src/dst fields), drive it, and
    // queue its beats as expected output when it should pass.
    task automatic send_frame(input int nbytes, input logic [15:0] et, input logic [31:0] src,
                              input logic [31:0] dst, input bit exp_pass, input int stop_after,
                              input int reconf_at, input bit rand_user, output int st);
        logic [7:0]  fb [];
        logic [63:0] d;
        logic [7:0]  k;
        logic        l, u;
        int          nb;
        st = 0;
        fb = new[nbytes];
        for (int i = 0; i < nbytes; i++) fb[i] = 8'((i * 7) + nbytes);
        for (int i = 0; i < 2; i++) if (12 + i < nbytes) fb[12 + i] = et[15 - 8*i -: 8];
        for (int i = 0; i < 4; i++) if (26 + i < nbytes) fb[26 + i] = src[31 - 8*i -: 8];
        for (int i = 0; i < 4; i++) if (30 + i < nbytes) fb[30 + i] = dst[31 - 8*i -: 8];
        nb = (nbytes + 7) / 8;
        if (stop_after > 0) nb = stop_after;
        for (int b = 0; b < nb; b++) begin
            d = '0; k = '0;
            for (int j = 0; j < 8; j++) begin
                if (b*8 + j < nbytes) begin
                    d[j*8 +: 8] = fb[b*8 + j];
                    k[j] = 1'b1;
                end
            end
            l = (stop_after == 0) && (b == nb - 1);
            u = rand_user ? 1'($urandom % 2) : 1'b0;
            if (b == reconf_at) addr_tx[0] = 32'h0B00_0000;
            if (exp_pass && stop_after == 0) exp_q.push_back({d, k, l, u});
            drive_beat(d, k, l, u, st);
        end
    endtask

    // Wait (bounded) for the expected beats, then compare count and contents in order.
    task automatic drain_compare(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        check({tag, "_beats"}, 74'(got_q.size()), 74'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_beat"}, got_q[i], exp_q[i]);
        end
        $display("frame %s: %0d beats out, %0d expected", tag, got_q.size(), exp_q.size());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        for (int i = 0; i < N; i++) begin
            vld_tx[i] = 1'b0; addr_tx[i] = '0; mask_tx[i] = '0;
            vld_rx[i] = 1'b0; addr_rx[i] = '0; mask_rx[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready_tx", 74'(rdy_tx), 74'(0));
        check("rst_tready_rx", 74'(rdy_rx), 74'(0));
        check("rst_mvalid_tx", 74'(mv_tx), 74'(0));
        check("rst_mdata_tx",  74'(md_tx), 74'(0));
        check("rst_dropcnt_tx", 74'(dc_tx), 74'(0));
        check("rst_dropcnt_rx", 74'(dc_rx), 74'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_tready_tx", 74'(rdy_tx), 74'(1));

        // TX drop by destination 10.0.0.5 against 10.0.0.0/24
        vld_tx[0] = 1'b1; addr_tx[0] = 32'h0A00_0000; mask_tx[0] = 32'hFFFF_FF00;
        send_frame(64, 16'h0800, 32'h0102_0304, 32'h0A00_0005, 1'b0, 0, -1, 1'b0, stalls);
        check("drop_stalls", 74'(stalls), 74'(1));
        drain_compare("drop_dst");
        check("drop_cnt_1", 74'(dc_tx), 74'(1));

        // Entry disabled: the same frame passes byte-exact
        vld_tx[0] = 1'b0;
        send_frame(64, 16'h0800, 32'h0102_0304, 32'h0A00_0005, 1'b1, 0, -1, 1'b0, stalls);
        check("pass_stalls", 74'(stalls), 74'(6));
        drain_compare("vld_off");
        check("drop_cnt_vld_off", 74'(dc_tx), 74'(1));

        // Non-IPv4 ethertype with a matching address passes
        vld_tx[0] = 1'b1;
        send_frame(64, 16'h0806, 32'h0102_0304, 32'h0A00_0005, 1'b1, 0, -1, 1'b0, stalls);
        drain_compare("arp");
        // 20-byte runt: three beats, last keep 0x0F, always passes
        send_frame(20, 16'h0800, 32'h0102_0304, 32'h0A00_0005, 1'b1, 0, -1, 1'b0, stalls);
        drain_compare("runt");
        check("drop_cnt_nonip", 74'(dc_tx), 74'(1));

        // RX source mode: entries 3 and 7 both hit 192.168.1.1/32
        sel = 1'b1;
        vld_rx[3] = 1'b1; addr_rx[3] = 32'hC0A8_0101; mask_rx[3] = 32'hFFFF_FFFF;
        vld_rx[7] = 1'b1; addr_rx[7] = 32'hC0A8_0101; mask_rx[7] = 32'hFFFF_FFFF;
        send_frame(64, 16'h0800, 32'hC0A8_0101, 32'h0102_0304, 1'b0, 0, -1, 1'b0, stalls);
        drain_compare("rx_src_drop");
        check("rx_drop_cnt", 74'(dc_rx), 74'(1));
        // Destination equal to the entry is ignored in source mode
        send_frame(64, 16'h0800, 32'h0A0A_0A0A, 32'hC0A8_0101, 1'b1, 0, -1, 1'b0, stalls);
        drain_compare("rx_dst_pass");
        check("rx_drop_cnt_2", 74'(dc_rx), 74'(1));
        sel = 1'b0;

        // Backpressure: 1500-byte frames back to back, random ready and tuser.
        // Entry0 is retargeted to 11.0.0.0/24 mid-frame: the frame in flight still
        // passes, the next one to 11.0.0.1 is dropped, the third passes.
        rand_ready = 1'b1;
        send_frame(1500, 16'h0800, 32'h0102_0304, 32'h0B00_0001, 1'b1, 0, 20, 1'b1, stalls);
        send_frame(1500, 16'h0800, 32'h0102_0304, 32'h0B00_0001, 1'b0, 0, -1, 1'b1, stalls);
        send_frame(1500, 16'h0800, 32'h0102_0304, 32'h0C00_0001, 1'b1, 0, -1, 1'b1, stalls);
        drain_compare("bp");
        check("bp_drop_cnt", 74'(dc_tx), 74'(2));
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during PASS
        addr_tx[0] = 32'h0A00_0000;
        send_frame(1500, 16'h0800, 32'h0102_0304, 32'h0C00_0001, 1'b0, 10, -1, 1'b0, stalls);
        s_tvalid = 1'b1;
        #1;
        check("pre_rst_passthru", 74'(mv_tx), 74'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_mvalid", 74'(mv_tx), 74'(0));
        check("midrst_dropcnt", 74'(dc_tx), 74'(0));
        check("midrst_tready", 74'(rdy_tx), 74'(0));
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(64, 16'h0800, 32'h0102_0304, 32'h0A00_0005, 1'b0, 0, -1, 1'b0, stalls);
        drain_compare("post_rst_drop");
        check("post_rst_dropcnt", 74'(dc_tx), 74'(1));
        send_frame(64, 16'h0800, 32'h0102_0304, 32'h0C00_0001, 1'b1, 0, -1, 1'b0, stalls);
        drain_compare("post_rst_pass");

        check("timeouts", 74'(timeouts), 74'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
